// File: rtl/digit_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : digit_serial_adder
// Description : Multi-cycle WIDTH-bit adder processing DIGIT bits per clock
//               with a start/busy/done handshake. Define ADDSUB_EN to add the
//               sub port and subtract mode.
// Revision    : 1.0 - initial release
// ============================================================================
module digit_serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADDSUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int STEPS  = WIDTH / DIGIT;
    localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic [WIDTH-1:0]    res_q;
    logic                carry_q;
    logic [STEP_W-1:0]   step_q;
    logic                busy_q;
    logic                done_q;
    logic [WIDTH-1:0]    sum_q;
    logic                cout_q;
    logic                ovf_q;

    logic [DIGIT:0]      slice_sum;
    logic [WIDTH-1:0]    res_d;
    logic                carry_d;
    logic                ovf_d;
    logic [WIDTH-1:0]    b_load;
    logic                carry_load;
    logic                last_step;

    always_comb begin
        slice_sum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                  + {{DIGIT{1'b0}}, carry_q};
        res_d     = (res_q >> DIGIT) | (WIDTH'(slice_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
        carry_d   = slice_sum[DIGIT];
        // On the last step the slice MSB is the operand MSB, so a^b^s recovers
        // the carry into the MSB without a separate flip-flop.
        ovf_d     = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ slice_sum[DIGIT-1] ^ slice_sum[DIGIT];
        last_step = (step_q == LAST_STEP);
`ifdef ADDSUB_EN
        b_load     = sub ? ~b : b;
        carry_load = sub ? 1'b1 : cin;
`else
        b_load     = b;
        carry_load = cin;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            step_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b_load;
                        carry_q <= carry_load;
                        step_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    a_q     <= a_q >> DIGIT;
                    b_q     <= b_q >> DIGIT;
                    res_q   <= res_d;
                    carry_q <= carry_d;
                    step_q  <= step_q + STEP_W'(1);
                    if (last_step) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        sum_q   <= res_d;
                        cout_q  <= carry_d;
                        ovf_q   <= ovf_d;
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule
`default_nettype wire
